pipeline_ctrl: RTL

Pipeline sequencing controller for the 2-bit-op/2-bit-inst CPU core. It watches the instructions in the decode (ID) and execute (EX) stages and drives the stage enables and flushes for the IF/ID, ID/EX and EX/MEM registers. It covers four cases: load-use stalls after CAR, flushes on taken SAL/SIG branches, multi-cycle MUL/MOD residency in EX, and the ESP halt-until-resume. It sits beside ControlUnit and does not replace it.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pipe_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 2-bit-op/2-bit-inst core and the pipeline controller state type.
package cpu_pkg;

    localparam logic [1:0] OP_JMP = 2'b00;
    localparam logic [1:0] OP_SYS = 2'b01;
    localparam logic [1:0] OP_MEM = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [1:0] INST_MUL = 2'b11;
    localparam logic [1:0] INST_MOD = 2'b10;
    localparam logic [1:0] INST_ESP = 2'b00;

    localparam int PIPECTRL_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MULTI = 2'b01,
        HALT  = 2'b10
    } pipectrl_state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator: flags a CAR in EX whose destination feeds a source read in ID.
// Purely combinational, no state.
module pipe_hazard_detect #(
    parameter int REG_BITS = 4
) (
    input  logic                ex_valid,
    input  logic                ex_rmem,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs2,
    output logic                o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = (ex_rd == id_rs1);
    assign w_rs2_hit  = id_uses_rs2 & (ex_rd == id_rs2);
    assign o_load_use = ex_valid & ex_rmem & id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage enable/flush sequencer for branch flush, load-use stall, multi-cycle MUL/MOD and ESP halt.
// Outputs are combinational from state plus inputs; PIPECTRL_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int REG_BITS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs2,
    input  logic                ex_valid,
    input  logic [1:0]          ex_op,
    input  logic [1:0]          ex_inst,
    input  logic                ex_imm,
    input  logic                ex_rmem,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_branch_taken,
    input  logic                resume,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic                exmem_bubble,
    output logic                halted,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         flush_cnt
);

    localparam bit MULDIV_EN     = (MULDIV_CYCLES > 1);
    localparam int MULTI_LOAD_I  = MULDIV_EN ? (MULDIV_CYCLES - 2) : 0;
    localparam logic [PIPECTRL_CNT_W-1:0] MULTI_LOAD = MULTI_LOAD_I[PIPECTRL_CNT_W-1:0];

    pipectrl_state_t             r_state;
    pipectrl_state_t             w_state_nxt;
    logic [PIPECTRL_CNT_W-1:0]   r_cnt;
    logic [PIPECTRL_CNT_W-1:0]   w_cnt_nxt;
    logic                        w_is_muldiv;
    logic                        w_is_esp;
    logic                        w_load_use;

    assign w_is_muldiv = ex_valid & (ex_op == OP_ALU) & ~ex_imm &
                         ((ex_inst == INST_MUL) | (ex_inst == INST_MOD));
    assign w_is_esp    = ex_valid & (ex_op == OP_SYS) & (ex_inst == INST_ESP);

    pipe_hazard_detect #(
        .REG_BITS (REG_BITS)
    ) u_hazard (
        .ex_valid    (ex_valid),
        .ex_rmem     (ex_rmem),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .o_load_use  (w_load_use)
    );

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        halted       = 1'b0;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
            w_state_nxt  = RUN;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (MULDIV_EN && w_is_muldiv) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_bubble = 1'b1;
                        w_cnt_nxt    = MULTI_LOAD;
                        w_state_nxt  = MULTI;
                    end else if (w_is_esp) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_flush  = 1'b1;
                        w_state_nxt = HALT;
                    end else if (w_load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                // The entry cycle in RUN already counted as one stall, hence the load of N-2.
                MULTI: begin
                    if (r_cnt != '0) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_bubble = 1'b1;
                        w_cnt_nxt    = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                HALT: begin
                    if (resume) begin
                        w_state_nxt = RUN;
                    end else begin
                        halted     = 1'b1;
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PIPECTRL_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_branch_flush;

    assign w_branch_flush = ~rst & (r_state == RUN) & ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_branch_flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
